// File: rtl/draw_control_fsm_if.sv
// Handshake bundle between the draw control FSM and its operator/datapath side.
// The master drives the operator inputs; the slave (the FSM) drives controls and pix_cnt.
interface draw_control_fsm_if #(
    parameter int CNT_W = 15
);
    logic             load;
    logic             clear;
    logic             ld_x;
    logic             ld_y;
    logic             ld_colour;
    logic             ctrl_reset;
    logic             count_up;
    logic             plot;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pix_cnt;

    modport master (
        output load, clear,
        input  ld_x, ld_y, ld_colour, ctrl_reset, count_up, plot, busy, done, pix_cnt
    );

    modport slave (
        input  load, clear,
        output ld_x, ld_y, ld_colour, ctrl_reset, count_up, plot, busy, done, pix_cnt
    );
endinterface

// File: rtl/draw_control_fsm.sv
// Control FSM for the pixel datapath: loads X/Y/colour from one button, plots a sprite,
// or clears the whole raster. All outputs are Moore, decoded from the state register.
module draw_control_fsm #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int BOX_SIZE = 4,
    parameter int CNT_W    = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    draw_control_fsm_if.slave    bus
);
    localparam logic [3:0] LD_X      = 4'd0;
    localparam logic [3:0] LD_X_W    = 4'd1;
    localparam logic [3:0] LD_Y      = 4'd2;
    localparam logic [3:0] LD_Y_W    = 4'd3;
    localparam logic [3:0] LD_C      = 4'd4;
    localparam logic [3:0] LD_C_W    = 4'd5;
    localparam logic [3:0] DRAW      = 4'd6;
    localparam logic [3:0] CLR_INIT  = 4'd7;
    localparam logic [3:0] CLR_SWEEP = 4'd8;
    localparam logic [3:0] FIN       = 4'd9;

    localparam logic [CNT_W-1:0] BOX_LAST    = CNT_W'(BOX_SIZE * BOX_SIZE - 1);
    localparam logic [CNT_W-1:0] SCREEN_LAST = CNT_W'(SCREEN_W * SCREEN_H - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_pix_cnt;
    logic             w_ld_x, w_ld_y, w_ld_colour, w_ctrl_reset;
    logic             w_count_up, w_plot, w_busy, w_done;

    // Clear is tested before load so a simultaneous press always clears.
    always_comb begin
        w_next = LD_X;
        case (r_state)
            LD_X:      w_next = bus.clear ? CLR_INIT : (bus.load ? LD_X_W : LD_X);
            LD_X_W:    w_next = bus.load ? LD_X_W : LD_Y;
            LD_Y:      w_next = bus.clear ? CLR_INIT : (bus.load ? LD_Y_W : LD_Y);
            LD_Y_W:    w_next = bus.load ? LD_Y_W : LD_C;
            LD_C:      w_next = bus.clear ? CLR_INIT : (bus.load ? LD_C_W : LD_C);
            LD_C_W:    w_next = bus.load ? LD_C_W : DRAW;
            DRAW:      w_next = (r_pix_cnt == BOX_LAST) ? FIN : DRAW;
            CLR_INIT:  w_next = CLR_SWEEP;
            CLR_SWEEP: w_next = (r_pix_cnt == SCREEN_LAST) ? FIN : CLR_SWEEP;
            FIN:       w_next = LD_X;
            default:   w_next = LD_X;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= LD_X;
            r_pix_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                LD_C_W:    if (!bus.load) r_pix_cnt <= '0;
                CLR_INIT:  r_pix_cnt <= '0;
                // Counter stops on the terminal pixel so FIN still shows the last index.
                DRAW:      if (r_pix_cnt != BOX_LAST) r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                CLR_SWEEP: if (r_pix_cnt != SCREEN_LAST) r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                default:   r_pix_cnt <= r_pix_cnt;
            endcase
        end
    end

    always_comb begin
        w_ld_x       = 1'b0;
        w_ld_y       = 1'b0;
        w_ld_colour  = 1'b0;
        w_ctrl_reset = 1'b0;
        w_count_up   = 1'b0;
        w_plot       = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            LD_X, LD_X_W:    w_ld_x = 1'b1;
            LD_Y, LD_Y_W:    w_ld_y = 1'b1;
            LD_C, LD_C_W:    w_ld_colour = 1'b1;
            DRAW, CLR_SWEEP: begin
                w_plot     = 1'b1;
                w_count_up = 1'b1;
                w_busy     = 1'b1;
            end
            CLR_INIT: begin
                w_ctrl_reset = 1'b1;
                w_busy       = 1'b1;
            end
            FIN:     w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.ld_x       = w_ld_x;
    assign bus.ld_y       = w_ld_y;
    assign bus.ld_colour  = w_ld_colour;
    assign bus.ctrl_reset = w_ctrl_reset;
    assign bus.count_up   = w_count_up;
    assign bus.plot       = w_plot;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.pix_cnt    = r_pix_cnt;
endmodule

// File: tb/tb_draw_control_fsm.sv
// Directed bench for draw_control_fsm: vector table for the load/draw path,
// hand-written sequences for clear sweeps, clear/load priority, held load and mid-sweep reset.
module tb_draw_control_fsm;
    // Output vector order: {ld_x, ld_y, ld_colour, ctrl_reset, count_up, plot, busy, done}
    localparam logic [7:0] O_LDX = 8'b1000_0000;
    localparam logic [7:0] O_LDY = 8'b0100_0000;
    localparam logic [7:0] O_LDC = 8'b0010_0000;
    localparam logic [7:0] O_CLI = 8'b0001_0010;
    localparam logic [7:0] O_DRW = 8'b0000_1110;
    localparam logic [7:0] O_FIN = 8'b0000_0001;

    typedef struct {
        logic        load;
        logic        clear;
        logic [7:0]  exp_o;
        logic [14:0] exp_cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    vec_t vt[$];

    draw_control_fsm_if #(.CNT_W(15)) bus ();

    draw_control_fsm #(
        .SCREEN_W(160),
        .SCREEN_H(120),
        .BOX_SIZE(4),
        .CNT_W(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {bus.ld_x, bus.ld_y, bus.ld_colour, bus.ctrl_reset,
                bus.count_up, bus.plot, bus.busy, bus.done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic cl, input logic [7:0] o,
                                input logic [14:0] c);
        vec_t v;
        v.load = ld; v.clear = cl; v.exp_o = o; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        int n;
        int errs;
        bus.load  = 1'b0;
        bus.clear = 1'b0;
        reset     = 1'b1;
        step();
        step();
        chk("reset_outs", 32'(outs()), 32'(O_LDX));
        chk("reset_cnt", 32'(bus.pix_cnt), 0);
        reset = 1'b0;

        // Load X, Y, colour with 1-high/2-low pulses, then the 16-pixel draw.
        vt.push_back(mk(1, 0, O_LDX, 0));
        vt.push_back(mk(0, 0, O_LDY, 0));
        vt.push_back(mk(0, 0, O_LDY, 0));
        vt.push_back(mk(1, 0, O_LDY, 0));
        vt.push_back(mk(0, 0, O_LDC, 0));
        vt.push_back(mk(0, 0, O_LDC, 0));
        vt.push_back(mk(1, 0, O_LDC, 0));
        vt.push_back(mk(0, 0, O_DRW, 0));
        for (int i = 1; i < 16; i++)
            vt.push_back(mk(i == 5, i == 9, O_DRW, 15'(i)));
        vt.push_back(mk(0, 0, O_FIN, 15));
        vt.push_back(mk(0, 0, O_LDX, 15));

        foreach (vt[i]) begin
            bus.load  = vt[i].load;
            bus.clear = vt[i].clear;
            step();
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp_o));
            chk($sformatf("vec%0d_cnt", i), 32'(bus.pix_cnt), 32'(vt[i].exp_cnt));
        end
        bus.load = 1'b0;

        // Full clear from LD_X.
        bus.clear = 1'b1;
        step();
        chk("clr_init_outs", 32'(outs()), 32'(O_CLI));
        bus.clear = 1'b0;
        n = 0;
        errs = 0;
        for (int c = 0; c < 20000; c++) begin
            step();
            if (!bus.plot) break;
            if (bus.pix_cnt !== 15'(n)) errs++;
            if (outs() !== O_DRW) errs++;
            n++;
        end
        chk("sweep_plot_cycles", n, 19200);
        chk("sweep_seq_errs", errs, 0);
        chk("sweep_fin_outs", 32'(outs()), 32'(O_FIN));
        chk("sweep_fin_cnt", 32'(bus.pix_cnt), 19199);
        step();
        chk("sweep_back_ldx", 32'(outs()), 32'(O_LDX));

        // Clear and load together in LD_Y, then reset at sweep pixel 1000.
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        chk("prio_in_ldy", 32'(outs()), 32'(O_LDY));
        bus.load  = 1'b1;
        bus.clear = 1'b1;
        step();
        chk("prio_clr_init", 32'(outs()), 32'(O_CLI));
        bus.load  = 1'b0;
        bus.clear = 1'b0;
        errs = 0;
        for (int c = 0; c < 1100; c++) begin
            step();
            if (bus.ld_y !== 1'b0) errs++;
            if (bus.pix_cnt == 15'd1000 || !bus.plot) break;
        end
        chk("prio_no_ldy", errs, 0);
        chk("mid_sweep_cnt", 32'(bus.pix_cnt), 1000);
        chk("mid_sweep_plot", 32'(bus.plot), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_sweep_outs", 32'(outs()), 32'(O_LDX));
        chk("rst_sweep_cnt", 32'(bus.pix_cnt), 0);
        step();
        chk("rst_sweep_no_done", 32'(outs()), 32'(O_LDX));

        // Holding load does not skip stages.
        bus.load = 1'b1;
        errs = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (outs() !== O_LDX) errs++;
        end
        chk("held_load_ldx", errs, 0);
        bus.load = 1'b0;
        step();
        chk("held_load_release", 32'(outs()), 32'(O_LDY));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
